// File: rtl/servo_ctrl_pkg.sv
// Shared encodings for the servo sequencer: FSM states, angle select codes,
// error codes and the expected monitor duty for each select.
package servo_ctrl_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_VERIFY = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    // Angle select codes shared with the PWM generator and pwm_monitor
    localparam logic [1:0] SEL_PARK = 2'd0;
    localparam logic [1:0] SEL_0    = 2'd1;
    localparam logic [1:0] SEL_90   = 2'd2;
    localparam logic [1:0] SEL_180  = 2'd3;

    // Sticky error codes
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_MISMATCH = 2'd2;

    // The monitor captures its counter one clock before the pulse falls,
    // so a pulse of N clocks reads back as N-1. Park has no pulse.
    function automatic int expected_duty(input logic [1:0] sel,
                                         input int a0,
                                         input int a90,
                                         input int a180);
        case (sel)
            SEL_0:   return a0 - 1;
            SEL_90:  return a90 - 1;
            SEL_180: return a180 - 1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/servo_cmd_fifo.sv
// Small synchronous command FIFO (power-of-two depth) holding host angle
// selects until the sequencer is ready to schedule them.
module servo_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic             Push_i,
    input  logic [WIDTH-1:0] Data_i,
    input  logic             Pop_i,
    output logic [WIDTH-1:0] Data_o,
    output logic             Full_o,
    output logic             Empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign Full_o  = (count_q == DEPTH_C);
    assign Empty_o = (count_q == '0);
    assign Data_o  = mem_q[rd_ptr_q];

    assign do_push = Push_i & ~Full_o;
    assign do_pop  = Pop_i & ~Empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers; reset empties the FIFO
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty
    always_ff @(posedge Clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= Data_i;
    end

endmodule

// File: rtl/servo_sequencer.sv
// Schedules angle selects onto the servo PWM path on frame boundaries and
// closes the loop against the pwm_monitor duty report.
//
// Handshake: a command is pushed on a clock edge where Cmd_Valid_i and
// Cmd_Ready_o are both high; Cmd_Ready_o never depends on Cmd_Valid_i, and
// is low while the FIFO is full or the sticky error is set.
module servo_sequencer #(
    parameter int FRAME_CYCLES     = 1000000,
    parameter int FRAME_CNT_W      = 20,
    parameter int ANGLE_0_CYCLES   = 25000,
    parameter int ANGLE_90_CYCLES  = 75000,
    parameter int ANGLE_180_CYCLES = 125000,
    parameter int DUTY_W           = 17,
    parameter int HOLD_FRAMES      = 25,
    parameter int TIMEOUT_FRAMES   = 3,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic              Clk_i,
    input  logic              Reset_i,
    input  logic [1:0]        Cmd_Sel_i,
    input  logic              Cmd_Valid_i,
    output logic              Cmd_Ready_o,
    input  logic              Sweep_En_i,
    input  logic              Err_Clr_i,
    input  logic              Available_i,
    input  logic [DUTY_W-1:0] Duty_Cycle_i,
    output logic [1:0]        Pwm_Sel_o,
    output logic              Frame_Start_o,
    output logic              Busy_o,
    output logic              Done_o,
    output logic              Error_o,
    output logic [1:0]        Err_Code_o
);
    import servo_ctrl_pkg::*;

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(FRAME_CYCLES - 1);
    localparam logic [HOLD_W-1:0]      HOLD_LAST  = HOLD_W'(HOLD_FRAMES);
    localparam logic [TO_W-1:0]        TO_LAST    = TO_W'(TIMEOUT_FRAMES);

    // Frame timer
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   frame_start_q;
    logic                   frame_wrap;

    // Sequencer state
    logic [2:0]        state_q, state_d;
    logic [1:0]        pending_q, pending_d;
    logic [1:0]        sel_q, sel_d;
    logic [TO_W-1:0]   timeout_q, timeout_d, timeout_inc;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    logic [1:0]        code_q, code_d;
    logic              done_d, done_q;
    logic [1:0]        sweep_q, sweep_d, sweep_step;
    logic              sweep_up_q, sweep_up_d;
    logic [DUTY_W-1:0] exp_duty;

    // FIFO interface
    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [1:0] fifo_dout;

    assign Error_o       = (state_q == ST_ERROR);
    assign Cmd_Ready_o   = ~fifo_full & ~Error_o;
    assign fifo_push     = Cmd_Valid_i & Cmd_Ready_o;
    assign Pwm_Sel_o     = sel_q;
    assign Frame_Start_o = frame_start_q;
    assign Busy_o        = (state_q != ST_IDLE);
    assign Done_o        = done_q;
    assign Err_Code_o    = code_q;

    assign frame_wrap  = (frame_cnt_q == FRAME_LAST);
    assign frame_cnt_d = frame_wrap ? '0 : frame_cnt_q + 1'b1;
    assign timeout_inc = timeout_q + 1'b1;
    assign hold_inc    = hold_q + 1'b1;
    assign sweep_step  = sweep_up_q ? (sweep_q + 2'd1) : (sweep_q - 2'd1);
    assign exp_duty    = DUTY_W'(expected_duty(sel_q, ANGLE_0_CYCLES,
                                               ANGLE_90_CYCLES, ANGLE_180_CYCLES));

    servo_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .Clk_i   (Clk_i),
        .Reset_i (Reset_i),
        .Push_i  (fifo_push),
        .Data_i  (Cmd_Sel_i),
        .Pop_i   (fifo_pop),
        .Data_o  (fifo_dout),
        .Full_o  (fifo_full),
        .Empty_o (fifo_empty)
    );

    // Free-running frame counter; Frame_Start_o is high while the count is 0
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_wrap;
        end
    end

    // Sequencer next-state: select loads only on the wrap edge so the new
    // select lines up with Frame_Start_o. The frame start seen in the first
    // VERIFY cycle counts toward the timeout.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        sel_d      = sel_q;
        timeout_d  = timeout_q;
        hold_d     = hold_q;
        code_d     = code_q;
        done_d     = 1'b0;
        sweep_d    = sweep_q;
        sweep_up_d = sweep_up_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    pending_d = fifo_dout;
                    state_d   = ST_ARM;
                end else if (Sweep_En_i) begin
                    pending_d = sweep_q;
                    sweep_d   = sweep_step;
                    if (sweep_step == SEL_180)   sweep_up_d = 1'b0;
                    else if (sweep_step == SEL_0) sweep_up_d = 1'b1;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (frame_wrap) begin
                    sel_d = pending_q;
                    if (pending_q == SEL_PARK) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_VERIFY;
                        timeout_d = '0;
                    end
                end
            end
            ST_VERIFY: begin
                if (Available_i) begin
                    if (Duty_Cycle_i == exp_duty) begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                    end else begin
                        state_d = ST_ERROR;
                        code_d  = ERR_MISMATCH;
                    end
                end else if (frame_start_q) begin
                    timeout_d = timeout_inc;
                    if (timeout_inc == TO_LAST) begin
                        state_d = ST_ERROR;
                        code_d  = ERR_TIMEOUT;
                    end
                end
            end
            ST_HOLD: begin
                if (frame_start_q) begin
                    hold_d = hold_inc;
                    if (hold_inc == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                if (frame_wrap) sel_d = SEL_PARK;
                if (Err_Clr_i) begin
                    state_d = ST_IDLE;
                    code_d  = ERR_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset aborts any command in flight
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q    <= ST_IDLE;
            pending_q  <= SEL_PARK;
            sel_q      <= SEL_PARK;
            timeout_q  <= '0;
            hold_q     <= '0;
            code_q     <= ERR_NONE;
            done_q     <= 1'b0;
            sweep_q    <= SEL_0;
            sweep_up_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            sel_q      <= sel_d;
            timeout_q  <= timeout_d;
            hold_q     <= hold_d;
            code_q     <= code_d;
            done_q     <= done_d;
            sweep_q    <= sweep_d;
            sweep_up_q <= sweep_up_d;
        end
    end

endmodule
